// File: rtl/div_pkg.sv
// Shared types and constants for the signed/unsigned divide sequencing stage.
// The optional DIV_ZERO_TRAP_EN build option is consumed by div_sign_seq.
package div_pkg;

  localparam int unsigned DIV_W = 16;
  localparam logic [DIV_W-1:0] DZ_QUOT = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    FIX,
    HOLD
  } div_state_t;

endpackage

// File: rtl/div_sign_seq_twos_neg.sv
// Combinational conditional two's-complement negate: y = en ? -x : x.
module twos_neg #(
  parameter int unsigned W = 16
) (
  input  logic         en_i,
  input  logic [W-1:0] x_i,
  output logic [W-1:0] y_c_o
);

  assign y_c_o = en_i ? (~x_i + W'(1)) : x_i;

endmodule

// File: rtl/div_sign_seq.sv
// Sign-handling sequencer around the external restoring divider.
// Build option DIV_ZERO_TRAP_EN: resolve zero divisors locally without launching the divider.
module div_sign_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quot,
  output logic [WIDTH-1:0] out_rem,
  output logic             out_dz,
  output logic             div_start,
  output logic [WIDTH-1:0] div_inbus1,
  output logic [WIDTH-1:0] div_inbus2,
  input  logic [WIDTH-1:0] div_cat,
  input  logic [WIDTH-1:0] div_rest,
  input  logic             div_done
);

  div_state_t state_q, state_d;

  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             div_start_q, div_start_d;
  logic [WIDTH-1:0] out_quot_q, out_quot_d;
  logic [WIDTH-1:0] out_rem_q, out_rem_d;
  logic             out_dz_q, out_dz_d;
  logic [WIDTH-1:0] inbus1_q, inbus1_d;
  logic [WIDTH-1:0] inbus2_q, inbus2_d;
  logic             qsign_q, qsign_d;
  logic             rsign_q, rsign_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] cat_q, cat_d;
  logic [WIDTH-1:0] rest_q, rest_d;
`ifdef DIV_ZERO_TRAP_EN
  logic [WIDTH-1:0] dividend_q, dividend_d;
`endif

  logic [WIDTH-1:0] mag_a_c, mag_b_c, quot_fix_c, rem_fix_c;

  // Operand magnitudes (0x8000 maps to itself) and result sign correction.
  twos_neg #(.W(WIDTH)) u_mag_a (
    .en_i (in_signed & in_dividend[WIDTH-1]),
    .x_i  (in_dividend),
    .y_c_o(mag_a_c)
  );

  twos_neg #(.W(WIDTH)) u_mag_b (
    .en_i (in_signed & in_divisor[WIDTH-1]),
    .x_i  (in_divisor),
    .y_c_o(mag_b_c)
  );

  twos_neg #(.W(WIDTH)) u_fix_q (
    .en_i (qsign_q),
    .x_i  (cat_q),
    .y_c_o(quot_fix_c)
  );

  twos_neg #(.W(WIDTH)) u_fix_r (
    .en_i (rsign_q),
    .x_i  (rest_q),
    .y_c_o(rem_fix_c)
  );

  // Next-state and next-output logic; handshake flags follow the next state.
  always_comb begin
    state_d    = state_q;
    out_quot_d = out_quot_q;
    out_rem_d  = out_rem_q;
    out_dz_d   = out_dz_q;
    inbus1_d   = inbus1_q;
    inbus2_d   = inbus2_q;
    qsign_d    = qsign_q;
    rsign_d    = rsign_q;
    dz_d       = dz_q;
    cat_d      = cat_q;
    rest_d     = rest_q;
`ifdef DIV_ZERO_TRAP_EN
    dividend_d = dividend_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          qsign_d  = in_signed & (in_dividend[WIDTH-1] ^ in_divisor[WIDTH-1]);
          rsign_d  = in_signed & in_dividend[WIDTH-1];
          inbus1_d = mag_a_c;
          inbus2_d = mag_b_c;
          dz_d     = (in_divisor == '0);
`ifdef DIV_ZERO_TRAP_EN
          dividend_d = in_dividend;
          state_d    = (in_divisor == '0) ? FIX : LAUNCH;
`else
          state_d    = LAUNCH;
`endif
        end
      end
      LAUNCH: state_d = WAIT;
      WAIT: begin
        if (div_done) begin
          cat_d   = div_cat;
          rest_d  = div_rest;
          state_d = FIX;
        end
      end
      FIX: begin
        out_quot_d = quot_fix_c;
        out_rem_d  = rem_fix_c;
        out_dz_d   = dz_q;
`ifdef DIV_ZERO_TRAP_EN
        if (dz_q) begin
          out_quot_d = WIDTH'(DZ_QUOT);
          out_rem_d  = dividend_q;
        end
`endif
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == HOLD);
    div_start_d = (state_d == LAUNCH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      div_start_q <= 1'b0;
      out_quot_q  <= '0;
      out_rem_q   <= '0;
      out_dz_q    <= 1'b0;
      inbus1_q    <= '0;
      inbus2_q    <= '0;
      qsign_q     <= 1'b0;
      rsign_q     <= 1'b0;
      dz_q        <= 1'b0;
      cat_q       <= '0;
      rest_q      <= '0;
`ifdef DIV_ZERO_TRAP_EN
      dividend_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      div_start_q <= div_start_d;
      out_quot_q  <= out_quot_d;
      out_rem_q   <= out_rem_d;
      out_dz_q    <= out_dz_d;
      inbus1_q    <= inbus1_d;
      inbus2_q    <= inbus2_d;
      qsign_q     <= qsign_d;
      rsign_q     <= rsign_d;
      dz_q        <= dz_d;
      cat_q       <= cat_d;
      rest_q      <= rest_d;
`ifdef DIV_ZERO_TRAP_EN
      dividend_q  <= dividend_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign div_start  = div_start_q;
  assign out_quot   = out_quot_q;
  assign out_rem    = out_rem_q;
  assign out_dz     = out_dz_q;
  assign div_inbus1 = inbus1_q;
  assign div_inbus2 = inbus2_q;

endmodule

// File: tb/tb_div_sign_seq.sv
// Self-checking bench for div_sign_seq with a behavioural divider and a result scoreboard.
module tb_div_sign_seq;

  localparam int DIV_LAT = 5;

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_signed;
  logic [15:0] in_dividend, in_divisor;
  logic        out_valid, out_ready;
  logic [15:0] out_quot, out_rem;
  logic        out_dz;
  logic        div_start;
  logic [15:0] div_inbus1, div_inbus2, div_cat, div_rest;
  logic        div_done;

  logic        mdl_done, spur_done;
  logic [15:0] mdl_cat, mdl_rest, lat_in1, lat_in2;
  int          cnt;
  int          start_cnt = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];

  div_sign_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_signed  (in_signed),
    .in_dividend(in_dividend),
    .in_divisor (in_divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_quot   (out_quot),
    .out_rem    (out_rem),
    .out_dz     (out_dz),
    .div_start  (div_start),
    .div_inbus1 (div_inbus1),
    .div_inbus2 (div_inbus2),
    .div_cat    (div_cat),
    .div_rest   (div_rest),
    .div_done   (div_done)
  );

  always #5 clk = ~clk;

  // Behavioural divider: done arrives DIV_LAT cycles after the start pulse.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= 0;
      mdl_done <= 1'b0;
      mdl_cat  <= 16'h0;
      mdl_rest <= 16'h0;
    end else begin
      mdl_done <= 1'b0;
      if (div_start) begin
        cnt       <= DIV_LAT - 1;
        lat_in1   <= div_inbus1;
        lat_in2   <= div_inbus2;
        start_cnt <= start_cnt + 1;
        if (div_inbus2 == 16'h0) begin
          mdl_cat  <= 16'hFFFF;
          mdl_rest <= div_inbus1;
        end else begin
          mdl_cat  <= div_inbus1 / div_inbus2;
          mdl_rest <= div_inbus1 % div_inbus2;
        end
      end else if (cnt != 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) mdl_done <= 1'b1;
      end
    end
  end

  assign div_done = mdl_done | spur_done;
  assign div_cat  = spur_done ? 16'hDEAD : mdl_cat;
  assign div_rest = spur_done ? 16'hBEEF : mdl_rest;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mag(input logic [15:0] x, input logic s);
    int v;
    v = s ? int'($signed(x)) : int'(x);
    if (v < 0) v = -v;
    return 16'(v);
  endfunction

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic s);
    exp_t e;
    int sa, sbv;
    if (b == 16'h0) begin
      e.q = 16'hFFFF; e.r = a; e.dz = 1'b1;
    end else begin
      sa  = s ? int'($signed(a)) : int'(a);
      sbv = s ? int'($signed(b)) : int'(b);
      e.q = 16'(sa / sbv);
      e.r = 16'(sa % sbv);
      e.dz = 1'b0;
    end
    return e;
  endfunction

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic s, input int hold);
    exp_t e;
    int   cyc;
    int   st0;
    logic trap;
    cyc = 0;
    while (in_ready !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    chk("in_ready_before_op", 32'(in_ready), 32'd1);
    trap = 1'b0;
`ifdef DIV_ZERO_TRAP_EN
    trap = (b == 16'h0);
`endif
    sb.push_back(model(a, b, s));
    st0 = start_cnt;
    in_valid = 1'b1; in_signed = s; in_dividend = a; in_divisor = b;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
    chk("latency", 32'(cyc), trap ? 32'd2 : 32'(3 + DIV_LAT));
    chk("start_pulses", 32'(start_cnt - st0), trap ? 32'd0 : 32'd1);
    if (!trap) begin
      chk("inbus1", 32'(lat_in1), 32'(mag(a, s)));
      chk("inbus2", 32'(lat_in2), 32'(mag(b, s)));
    end
    e = sb.pop_front();
    chk("quot", 32'(out_quot), 32'(e.q));
    chk("rem", 32'(out_rem), 32'(e.r));
    chk("dz", 32'(out_dz), 32'(e.dz));
    for (int i = 0; i < hold; i++) begin
      spur_done = (i == 3);
      @(negedge clk);
      spur_done = 1'b0;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_quot", 32'(out_quot), 32'(e.q));
      chk("hold_rem", 32'(out_rem), 32'(e.r));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_after_accept", 32'(out_valid), 32'd0);
    chk("ready_after_accept", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_signed = 1'b0; in_dividend = 16'h0;
    in_divisor = 16'h0; out_ready = 1'b0; spur_done = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_div_start", 32'(div_start), 32'd0);
    chk("rst_quot", 32'(out_quot), 32'd0);
    chk("rst_rem", 32'(out_rem), 32'd0);
    chk("rst_dz", 32'(out_dz), 32'd0);
    chk("rst_inbus1", 32'(div_inbus1), 32'd0);
    chk("rst_inbus2", 32'(div_inbus2), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("ready_before_first_edge", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("ready_after_release", 32'(in_ready), 32'd1);

    do_op(16'd100, 16'd7, 1'b0, 0);
    do_op(16'hFF9C, 16'd7, 1'b1, 0);
    do_op(16'd100, 16'hFFF9, 1'b1, 0);
    do_op(16'h8000, 16'hFFFF, 1'b1, 0);
    do_op(16'd55, 16'd0, 1'b0, 0);

    // Stray done while idle must be ignored.
    spur_done = 1'b1; @(negedge clk); spur_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (rb == 16'h0) rb = 16'd3;
      do_op(ra, rb, 1'($urandom_range(0, 1)), 0);
    end

    do_op(16'd30000, 16'd7, 1'b0, 10);
    do_op(16'hFFF9, 16'd2, 1'b1, 0);

    // Abort while the divider is busy.
    in_valid = 1'b1; in_signed = 1'b0; in_dividend = 16'd1000; in_divisor = 16'd3;
    @(negedge clk); in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_quot", 32'(out_quot), 32'd0);
    chk("abort_rem", 32'(out_rem), 32'd0);
    chk("abort_inbus1", 32'(div_inbus1), 32'd0);
    chk("abort_inbus2", 32'(div_inbus2), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready_after_release", 32'(in_ready), 32'd1);
    do_op(16'd9, 16'd3, 1'b0, 0);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
